// File: rtl/fetch_unit_if.sv
// fetch_unit_if: I-cache request/response bus plus the IF/ID packet bus leaving fetch
interface fetch_unit_if;
    typedef struct packed {
        logic [31:0] inst;
        logic [31:0] pc;
        logic [31:0] npc;
        logic        valid;
    } if_id_packet_t;
    logic                 proc2Icache_req;
    logic [2:0][31:0]     proc2Icache_addr;
    logic [2:0]           Icache_hit;
    logic [2:0][31:0]     Icache_data;
    if_id_packet_t [2:0]  if_packet_out;
    modport master (
        output proc2Icache_req, proc2Icache_addr, if_packet_out,
        input  Icache_hit, Icache_data
    );
    modport slave (
        input  proc2Icache_req, proc2Icache_addr, if_packet_out,
        output Icache_hit, Icache_data
    );
endinterface

// File: rtl/fetch_unit.sv
// fetch_unit: three-wide in-order fetch, PC register + FETCH/MISS/STALL FSM + saturating stall counter
module fetch_unit (
    input  logic                clock,
    input  logic                reset,
    input  logic                enable,
    input  logic                squash_flag,
    input  logic [31:0]         squash_target_pc,
    input  logic                insn_buffer_full,
    fetch_unit_if.master        bus,
    output logic [1:0]          fetch_state,
    output logic [15:0]         stall_cycles
);
    localparam logic [1:0]  FETCH = 2'd0, MISS = 2'd1, STALL = 2'd2;
    localparam logic [31:0] NOP   = 32'h0000_0013;
    logic [31:0] pc, pc_next;
    logic [1:0]  state, state_next;
    logic [15:0] stall_next;
    logic [1:0]  k;
    logic        active, req;
    assign active = enable && !squash_flag;
    assign req    = !reset && active && !insn_buffer_full;
    // only the unbroken run of hits from slot 0 is usable
    assign k = !bus.Icache_hit[0] ? 2'd0 : !bus.Icache_hit[1] ? 2'd1 : !bus.Icache_hit[2] ? 2'd2 : 2'd3;
    always_ff @(posedge clock) begin
        if (reset) begin
            pc           <= '0;
            state        <= FETCH;
            stall_cycles <= '0;
        end else begin
            pc           <= pc_next;
            state        <= state_next;
            stall_cycles <= stall_next;
        end
    end
    always_comb begin
        pc_next    = !enable ? pc : squash_flag ? (squash_target_pc & ~32'h3) : req ? pc + 32'({k, 2'b00}) : pc;
        state_next = !active ? (enable ? FETCH : state) : insn_buffer_full ? STALL : k == 2'd0 ? MISS : FETCH;
        stall_next = active && (insn_buffer_full || k == 2'd0) && stall_cycles != 16'hFFFF ? stall_cycles + 16'd1 : stall_cycles;
    end
    always_comb begin
        fetch_state         = state;
        bus.proc2Icache_req = req;
        bus.proc2Icache_addr = '0;
        bus.if_packet_out    = '0;
        for (int i = 0; i < 3; i++) begin
            bus.proc2Icache_addr[i]      = pc + 32'(4 * i);
            bus.if_packet_out[i].valid   = req && i < int'(k);
            bus.if_packet_out[i].inst    = bus.if_packet_out[i].valid ? bus.Icache_data[i] : NOP;
            bus.if_packet_out[i].pc      = bus.if_packet_out[i].valid ? pc + 32'(4 * i) : 32'd0;
            bus.if_packet_out[i].npc     = bus.if_packet_out[i].valid ? pc + 32'(4 * i + 4) : 32'd0;
        end
    end
endmodule
